cache_ctrl_8way: RTL and testbench

Control FSM for the 8-way set-associative cache. It sits between the CPU-side request port, the per-way tag/valid/dirty/data arrays and the pseudo-LRU tree. It detects hits, picks a victim on a miss (invalid way first, otherwise the pLRU way), sequences a dirty writeback and line fetch over the physical-memory port, and drives the pLRU update. It also keeps saturating hit/miss/writeback counters for performance debug.

---
 rtl/cache_ctrl_8way.sv | 167 ++++++++++++++++
 tb/tb_cache_ctrl_8way.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_8way.sv
// Control FSM for an 8-way set-associative cache: hit detection, victim choice,
// dirty writeback and line fetch sequencing, pLRU update and saturating perf counters.
module cache_ctrl_8way #(
  parameter int s_cnt = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  input  logic [7:0]       hit_vec,
  input  logic [7:0]       valid_vec,
  input  logic [7:0]       dirty_vec,
  input  logic [2:0]       plru,
  output logic             plru_load,
  output logic [2:0]       plru_access,
  output logic [2:0]       way_sel,
  output logic             load_data,
  output logic             load_tag,
  output logic             set_valid,
  output logic             set_dirty,
  output logic             clr_dirty,
  output logic             cpu_wr_en,
  output logic             pmem_addr_sel,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  output logic             multi_hit_err,
  output logic [s_cnt-1:0] hit_cnt,
  output logic [s_cnt-1:0] miss_cnt,
  output logic [s_cnt-1:0] wb_cnt
);

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_t;

  localparam logic [s_cnt-1:0] cnt_one = {{(s_cnt-1){1'b0}}, 1'b1};
  localparam logic [s_cnt-1:0] cnt_max = {s_cnt{1'b1}};

  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic more_than_one(input logic [7:0] v);
    return |(v & (v - 8'd1));
  endfunction

  state_t     state_r, state_next;
  logic [2:0] victim_r, victim_next;
  logic       request_s;
  logic [2:0] hit_way_s;
  logic [2:0] victim_pick_s;
  logic       hit_inc_s, miss_inc_s, wb_inc_s;

  assign request_s     = mem_read | mem_write;
  assign hit_way_s     = lowest_set(hit_vec);
  // An invalid way is always preferred over evicting a live line.
  assign victim_pick_s = (valid_vec != 8'hFF) ? lowest_set(~valid_vec) : plru;

  // Next-state, victim capture and all control strobes.
  always_comb begin
    state_next    = state_r;
    victim_next   = victim_r;
    mem_resp      = 1'b0;
    plru_load     = 1'b0;
    plru_access   = 3'd0;
    way_sel       = 3'd0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    set_valid     = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    cpu_wr_en     = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    hit_inc_s     = 1'b0;
    miss_inc_s    = 1'b0;
    wb_inc_s      = 1'b0;
    if (rst) begin
      state_next  = CHECK;
      victim_next = 3'd0;
    end else begin
      case (state_r)
        CHECK: begin
          if (request_s && (hit_vec != 8'h00)) begin
            way_sel     = hit_way_s;
            mem_resp    = 1'b1;
            plru_load   = 1'b1;
            plru_access = hit_way_s;
            cpu_wr_en   = mem_write;
            set_dirty   = mem_write;
            hit_inc_s   = 1'b1;
          end else if (request_s) begin
            victim_next = victim_pick_s;
            miss_inc_s  = 1'b1;
            if (valid_vec[victim_pick_s] && dirty_vec[victim_pick_s]) begin
              state_next = WRITEBACK;
            end else begin
              state_next = FETCH;
            end
          end else begin
            state_next = CHECK;
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim_r;
          if (pmem_resp) begin
            wb_inc_s   = 1'b1;
            clr_dirty  = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WRITEBACK;
          end
        end
        FETCH: begin
          pmem_read = 1'b1;
          way_sel   = victim_r;
          if (pmem_resp) begin
            load_data  = 1'b1;
            load_tag   = 1'b1;
            set_valid  = 1'b1;
            clr_dirty  = 1'b1;
            state_next = CHECK;
          end else begin
            state_next = FETCH;
          end
        end
        default: begin
          state_next = CHECK;
        end
      endcase
    end
  end

  // State, victim, sticky error flag and saturating counters.
  always_ff @(posedge clk) begin
    state_r  <= state_next;
    victim_r <= victim_next;
    if (rst) begin
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      wb_cnt        <= '0;
      multi_hit_err <= 1'b0;
    end else begin
      if (hit_inc_s && (hit_cnt != cnt_max)) hit_cnt <= hit_cnt + cnt_one;
      if (miss_inc_s && (miss_cnt != cnt_max)) miss_cnt <= miss_cnt + cnt_one;
      if (wb_inc_s && (wb_cnt != cnt_max)) wb_cnt <= wb_cnt + cnt_one;
      if (more_than_one(hit_vec)) multi_hit_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_ctrl_8way.sv
// Self-checking bench for cache_ctrl_8way: table-driven hit vectors through a
// scoreboard queue, plus hand sequences for misses, writeback, reset and saturation.
module tb_cache_ctrl_8way;

  logic        clk = 1'b0;
  logic        rst, mem_read, mem_write, mem_resp;
  logic [7:0]  hit_vec, valid_vec, dirty_vec;
  logic [2:0]  plru, plru_access, way_sel;
  logic        plru_load, load_data, load_tag, set_valid, set_dirty, clr_dirty;
  logic        cpu_wr_en, pmem_addr_sel, pmem_read, pmem_write, pmem_resp, multi_hit_err;
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_ctrl_8way #(.s_cnt(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .plru(plru),
    .plru_load(plru_load), .plru_access(plru_access), .way_sel(way_sel),
    .load_data(load_data), .load_tag(load_tag), .set_valid(set_valid), .set_dirty(set_dirty),
    .clr_dirty(clr_dirty), .cpu_wr_en(cpu_wr_en), .pmem_addr_sel(pmem_addr_sel),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .multi_hit_err(multi_hit_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  typedef struct {
    logic       rd, wr;
    logic [7:0] hv, vv, dv;
    logic [2:0] pl;
    logic       resp;
    logic [2:0] way;
    logic       pl_load;
    logic [2:0] pl_acc;
    logic       wr_en, sdirty, pread, pwrite;
  } vec_t;

  vec_t tbl [6];
  vec_t exp_q [$];
  vec_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 8'h20, 8'hFF, 8'h00, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h20, 8'hFF, 8'h00, 3'd0, 1'b1, 3'd5, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 8'h04, 8'hFF, 8'h00, 3'd0, 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'h80, 8'hFF, 8'h00, 3'd3, 1'b1, 3'd7, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h01, 8'hFF, 8'h00, 3'd4, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 8'h7F, 8'hFF, 3'd5, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset with a request and a hit present: every strobe must stay low.
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; hit_vec = 8'h20;
    valid_vec = 8'hFF; dirty_vec = 8'h00; plru = 3'd0; pmem_resp = 1'b0;
    @(negedge clk);
    chk("rst_mem_resp", 32'(mem_resp), 32'd0);
    chk("rst_plru_load", 32'(plru_load), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    chk("rst_wb_cnt", wb_cnt, 32'd0);
    chk("rst_multi_hit", 32'(multi_hit_err), 32'd0);
    next_cycle();
    rst = 1'b0; mem_read = 1'b0; hit_vec = 8'h00;

    // Single-cycle CHECK vectors through the scoreboard.
    for (int i = 0; i < 6; i++) begin
      mem_read = tbl[i].rd; mem_write = tbl[i].wr; hit_vec = tbl[i].hv;
      valid_vec = tbl[i].vv; dirty_vec = tbl[i].dv; plru = tbl[i].pl;
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("v%0d_mem_resp", i), 32'(mem_resp), 32'(e.resp));
      chk($sformatf("v%0d_way_sel", i), 32'(way_sel), 32'(e.way));
      chk($sformatf("v%0d_plru_load", i), 32'(plru_load), 32'(e.pl_load));
      chk($sformatf("v%0d_plru_access", i), 32'(plru_access), 32'(e.pl_acc));
      chk($sformatf("v%0d_cpu_wr_en", i), 32'(cpu_wr_en), 32'(e.wr_en));
      chk($sformatf("v%0d_set_dirty", i), 32'(set_dirty), 32'(e.sdirty));
      chk($sformatf("v%0d_pmem_read", i), 32'(pmem_read), 32'(e.pread));
      chk($sformatf("v%0d_pmem_write", i), 32'(pmem_write), 32'(e.pwrite));
      next_cycle();
    end
    mem_read = 1'b0; mem_write = 1'b0; hit_vec = 8'h00; valid_vec = 8'hFF;
    @(negedge clk);
    chk("table_hit_cnt", hit_cnt, 32'd4);
    chk("table_miss_cnt", miss_cnt, 32'd0);

    // Clean read miss: invalid way 3 chosen, fill after 5 fetch cycles.
    next_cycle();
    mem_read = 1'b1; hit_vec = 8'h00; valid_vec = 8'hF7; dirty_vec = 8'hFF; plru = 3'd1;
    @(negedge clk);
    chk("cm_check_resp", 32'(mem_resp), 32'd0);
    chk("cm_check_pread", 32'(pmem_read), 32'd0);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("cm_fetch_pread", 32'(pmem_read), 32'd1);
      chk("cm_fetch_pwrite", 32'(pmem_write), 32'd0);
      chk("cm_fetch_way", 32'(way_sel), 32'd3);
      chk("cm_fetch_load", 32'(load_data), 32'd0);
      next_cycle();
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("cm_fill_load_data", 32'(load_data), 32'd1);
    chk("cm_fill_load_tag", 32'(load_tag), 32'd1);
    chk("cm_fill_set_valid", 32'(set_valid), 32'd1);
    chk("cm_fill_way", 32'(way_sel), 32'd3);
    chk("cm_fill_plru_load", 32'(plru_load), 32'd0);
    chk("cm_fill_resp", 32'(mem_resp), 32'd0);
    next_cycle();
    pmem_resp = 1'b0; hit_vec = 8'h08; valid_vec = 8'hFF;
    @(negedge clk);
    chk("cm_hit_resp", 32'(mem_resp), 32'd1);
    chk("cm_hit_way", 32'(way_sel), 32'd3);
    chk("cm_hit_plru_access", 32'(plru_access), 32'd3);
    chk("cm_hit_pread", 32'(pmem_read), 32'd0);
    next_cycle();
    mem_read = 1'b0; hit_vec = 8'h00;
    @(negedge clk);
    chk("cm_miss_cnt", miss_cnt, 32'd1);
    chk("cm_hit_cnt", hit_cnt, 32'd5);

    // Dirty miss on pLRU way 6: writeback then fetch, victim held while plru moves.
    next_cycle();
    mem_read = 1'b1; valid_vec = 8'hFF; dirty_vec = 8'h40; plru = 3'd6;
    @(negedge clk);
    chk("dm_check_pwrite", 32'(pmem_write), 32'd0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("dm_wb_pwrite", 32'(pmem_write), 32'd1);
      chk("dm_wb_pread", 32'(pmem_read), 32'd0);
      chk("dm_wb_addr_sel", 32'(pmem_addr_sel), 32'd1);
      chk("dm_wb_way", 32'(way_sel), 32'd6);
      next_cycle();
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("dm_wb_clr_dirty", 32'(clr_dirty), 32'd1);
    chk("dm_wb_no_load", 32'(load_data), 32'd0);
    next_cycle();
    pmem_resp = 1'b0; plru = 3'd2; dirty_vec = 8'h00;
    @(negedge clk);
    chk("dm_fetch_pwrite", 32'(pmem_write), 32'd0);
    chk("dm_fetch_pread", 32'(pmem_read), 32'd1);
    chk("dm_fetch_addr_sel", 32'(pmem_addr_sel), 32'd0);
    chk("dm_fetch_way_held", 32'(way_sel), 32'd6);
    chk("dm_wb_cnt", wb_cnt, 32'd1);
    next_cycle();
    pmem_resp = 1'b1;
    @(negedge clk);
    chk("dm_fill_load", 32'(load_data), 32'd1);
    chk("dm_fill_way", 32'(way_sel), 32'd6);
    next_cycle();
    pmem_resp = 1'b0; hit_vec = 8'h40;
    @(negedge clk);
    chk("dm_hit_resp", 32'(mem_resp), 32'd1);
    chk("dm_hit_plru_access", 32'(plru_access), 32'd6);
    next_cycle();
    mem_read = 1'b0; hit_vec = 8'h00;
    @(negedge clk);
    chk("dm_miss_cnt", miss_cnt, 32'd2);
    chk("dm_hit_cnt", hit_cnt, 32'd6);

    // Multiple hits: lowest way wins, error flag is sticky.
    next_cycle();
    mem_read = 1'b1; hit_vec = 8'h11;
    @(negedge clk);
    chk("mh_way", 32'(way_sel), 32'd0);
    chk("mh_flag_before", 32'(multi_hit_err), 32'd0);
    next_cycle();
    mem_read = 1'b0; hit_vec = 8'h00;
    @(negedge clk);
    chk("mh_flag_set", 32'(multi_hit_err), 32'd1);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("mh_flag_sticky", 32'(multi_hit_err), 32'd1);

    // Reset in the second fetch cycle, with pmem_resp arriving in that cycle.
    next_cycle();
    mem_read = 1'b1; hit_vec = 8'h00; valid_vec = 8'hFE; dirty_vec = 8'h00; plru = 3'd4;
    next_cycle();
    @(negedge clk);
    chk("rf_fetch1_pread", 32'(pmem_read), 32'd1);
    next_cycle();
    rst = 1'b1; pmem_resp = 1'b1;
    @(negedge clk);
    chk("rf_rst_pread", 32'(pmem_read), 32'd0);
    chk("rf_rst_load", 32'(load_data), 32'd0);
    chk("rf_rst_set_valid", 32'(set_valid), 32'd0);
    next_cycle();
    rst = 1'b0; pmem_resp = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("rf_after_pread", 32'(pmem_read), 32'd0);
    chk("rf_after_hit_cnt", hit_cnt, 32'd0);
    chk("rf_after_miss_cnt", miss_cnt, 32'd0);
    chk("rf_after_multi", 32'(multi_hit_err), 32'd0);
    next_cycle();
    mem_read = 1'b1; hit_vec = 8'h02; valid_vec = 8'hFF;
    @(negedge clk);
    chk("rf_check_resp", 32'(mem_resp), 32'd1);
    chk("rf_check_way", 32'(way_sel), 32'd1);

    // Hit counter saturates at all-ones.
    next_cycle();
    force dut.hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.hit_cnt;
    hit_vec = 8'h01;
    @(negedge clk);
    chk("sat_preload", hit_cnt, 32'hFFFF_FFFE);
    next_cycle();
    @(negedge clk);
    chk("sat_reach_max", hit_cnt, 32'hFFFF_FFFF);
    repeat (3) next_cycle();
    @(negedge clk);
    chk("sat_hold_max", hit_cnt, 32'hFFFF_FFFF);
    mem_read = 1'b0; hit_vec = 8'h00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
